cpu_sequencer: RTL
==================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 3, number of phases per microstep (legal range 2..8).
REQ-002 SHALL have parameter MAX_STEPS, default 16, number of microsteps per instruction (legal range 2..256); STEP_W = clog2(MAX_STEPS).
REQ-003 SHALL have parameter IRQ_EN, default 1, which enables interrupt acceptance when 1 and ties irq_ack/in_irq low when 0.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 phase_en  out  NUM_PHASES  one-hot phase strobe, replacing derived clocks; all-zero when halted.
REQ-007 step_cnt  out  STEP_W  current microstep index within the instruction.
REQ-008 step_reset  in  1  microcode "next instruction"; sampled only in the last phase.
REQ-009 halt_req  in  1  level; stop at the end of the current microstep.
REQ-010 single_step  in  1  level; stop at every instruction boundary.
REQ-011 resume  in  1  pulse; leave HALT.
REQ-012 irq  in  1  level interrupt request.
REQ-013 irq_ret  in  1  pulse from the return-from-interrupt microstep.
REQ-014 irq_ack  out  1  one-cycle pulse when an interrupt is accepted.
REQ-015 in_irq  out  1  high while the interrupt handler is active.
REQ-016 halted  out  1  high while in HALT.
REQ-017 step_ovf  out  1  sticky error flag for microstep counter overflow.

Function
REQ-018 SHALL implement two states: RUN and HALT.
REQ-019 In RUN, the phase counter SHALL advance 0,1,..,NUM_PHASES-1,0 once per clk, and phase_en[k] SHALL be 1 exactly while phase == k.
REQ-020 "Last phase" SHALL mean the cycle in which phase == NUM_PHASES-1 in RUN; an "instruction boundary" SHALL mean last phase AND step_reset == 1.
REQ-021 At last phase, step_cnt SHALL become 0 if step_reset is 1; otherwise it SHALL increment.
REQ-022 At last phase, if step_cnt == MAX_STEPS-1 and step_reset is 0, step_cnt SHALL wrap to 0 and step_ovf SHALL set and stay set until reset.
REQ-023 At last phase, if halt_req is 1, the next state SHALL be HALT.
REQ-024 At an instruction boundary, if single_step is 1, the next state SHALL be HALT.
REQ-025 At an instruction boundary, if IRQ_EN=1, irq=1 and in_irq=0, the block SHALL accept the interrupt:
  - irq_ack pulses in the following cycle;
  - in_irq sets;
  - acceptance is independent of a simultaneous transition to HALT.
REQ-026 in_irq SHALL clear on the clk after irq_ret=1 at an instruction boundary; irq_ret at any other time SHALL be ignored.
REQ-027 While in_irq=1, further irq SHALL be masked (no nesting).
REQ-028 In HALT:
  - phase_en SHALL be 0, halted SHALL be 1;
  - step_cnt and in_irq SHALL hold;
  - phase SHALL be held at 0.
REQ-029 In HALT, resume=1 SHALL return to RUN on the next clk starting at phase 0; halt_req is not re-sampled until the next last phase.
REQ-030 resume in RUN SHALL be ignored.
REQ-031 Latency from last-phase sampling of halt_req to halted=1 SHALL be one clk.

Reset
REQ-032 On reset low, the block SHALL immediately enter RUN, phase 0, with outputs:
  - phase_en = 1 (bit 0);
  - step_cnt = 0;
  - irq_ack = 0, in_irq = 0;
  - halted = 0, step_ovf = 0.
REQ-033 Reset asserted mid-instruction or in HALT SHALL abandon all state with no pending ack.
REQ-034 The first phase advance SHALL occur on the first rising clk edge after reset deasserts.

Structure
REQ-035 The state encoding (RUN/HALT) and the parameter legal-range limits SHALL live in the shared CPU parameters package.
REQ-036 The phase rotator SHALL be one sub-module, phase_gen (ports clk, reset, run, phase_en, last), instantiated once.
REQ-037 No derived or gated clocks; all consumers use phase_en as enables.

Verification
REQ-038 Defaults, reset released, step_reset=1 on every last phase:
  - phase_en cycles 001,010,100;
  - step_cnt stays 0;
  - halted=0.
REQ-039 halt_req=1 during phase 1 of step 2, held:
  - halted=1 one clk after phase 2;
  - step_cnt=3 held;
  - resume pulse -> phase_en=001 next clk.
REQ-040 single_step=1, program with 4-step instructions:
  - HALT after each boundary with step_cnt=0;
  - each resume executes exactly 12 clks of phase_en activity.
REQ-041 irq=1 at boundary with in_irq=0:
  - irq_ack is a single-clk pulse, in_irq=1;
  - second irq at next boundary gives no ack;
  - irq_ret at boundary clears in_irq.
REQ-042 MAX_STEPS=4, step_reset held 0:
  - step_cnt 0,1,2,3,0;
  - step_ovf=1 and sticky.
REQ-043 Reset pulsed low during HALT with in_irq=1:
  - all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// Shared CPU sequencer definitions: sequencer state encoding and the legal
// parameter ranges checked by the sequencer at elaboration.
package cpu_sequencer_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } seq_state_e;

    localparam int MIN_PHASES = 2;
    localparam int MAX_PHASES = 8;
    localparam int MIN_STEPS  = 2;
    localparam int MAX_STEPS_LIMIT = 256;

    function automatic bit params_legal(input int num_phases, input int max_steps);
        return (num_phases >= MIN_PHASES) && (num_phases <= MAX_PHASES) &&
               (max_steps >= MIN_STEPS) && (max_steps <= MAX_STEPS_LIMIT);
    endfunction

endpackage

// File: rtl/cpu_sequencer_phase_gen.sv
// Phase rotator: one-hot phase strobe that replaces derived clocks.
// Phase parks at 0 whenever run is low, so a restart always begins at phase 0.
module phase_gen #(
    parameter int NUM_PHASES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic                  last
);

    localparam int PH_W = $clog2(NUM_PHASES);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

    logic [PH_W-1:0] phase;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (!run || (phase == LAST_PH)) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    always_comb begin
        phase_en = '0;
        for (int k = 0; k < NUM_PHASES; k++) begin
            phase_en[k] = run && (phase == PH_W'(k));
        end
        last = run && (phase == LAST_PH);
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Microstep sequencer: phase strobes, microstep counter, halt/single-step
// control and single-level (non-nesting) interrupt acceptance.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int NUM_PHASES = 3,
    parameter int MAX_STEPS  = 16,
    parameter int IRQ_EN     = 1,
    localparam int STEP_W    = $clog2(MAX_STEPS)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic [STEP_W-1:0]     step_cnt,
    input  logic                  step_reset,
    input  logic                  halt_req,
    input  logic                  single_step,
    input  logic                  resume,
    input  logic                  irq,
    input  logic                  irq_ret,
    output logic                  irq_ack,
    output logic                  in_irq,
    output logic                  halted,
    output logic                  step_ovf
);

    localparam bit IRQ_ON = (IRQ_EN != 0);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS - 1);

    if (!params_legal(NUM_PHASES, MAX_STEPS)) begin : g_param_check
        $error("cpu_sequencer: NUM_PHASES or MAX_STEPS outside legal range");
    end

    seq_state_e state;
    seq_state_e next_state;
    logic       run;
    logic       last;
    logic       boundary;
    logic       accept;
    logic       step_at_max;

    phase_gen #(
        .NUM_PHASES(NUM_PHASES)
    ) u_phase_gen (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .phase_en(phase_en),
        .last    (last)
    );

    assign boundary    = last && step_reset;
    assign step_at_max = (step_cnt == STEP_MAX);
    assign accept      = IRQ_ON && boundary && irq && !in_irq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Halt requests only take effect at the end of a microstep; single-step
    // only at an instruction boundary.
    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (last && (halt_req || (step_reset && single_step))) begin
                    next_state = HALT;
                end
            end
            HALT: begin
                if (resume) begin
                    next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        run    = (state == RUN);
        halted = (state == HALT);
    end

    // Counter wraps at MAX_STEPS-1 even without step_reset; that wrap is the
    // overflow condition latched into the sticky flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_cnt <= '0;
            step_ovf <= 1'b0;
            irq_ack  <= 1'b0;
            in_irq   <= 1'b0;
        end else begin
            irq_ack <= accept;
            if (last) begin
                if (step_reset || step_at_max) begin
                    step_cnt <= '0;
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
                if (!step_reset && step_at_max) begin
                    step_ovf <= 1'b1;
                end
            end
            if (accept) begin
                in_irq <= 1'b1;
            end else if (boundary && irq_ret) begin
                in_irq <= 1'b0;
            end
        end
    end

endmodule
